// File: rtl/uart_rx_frontend_pkg.sv
// Shared UART definitions: receiver FSM state codes, oversampling constants and
// the baud divider helper. Intended to be reused by the transmit side.
package uart_rx_frontend_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int calc_div(input int clock_freq, input int baud);
    int d;
    d = (clock_freq + 8 * baud) / (16 * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through receive FIFO.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, din   write request and data
//   pop         read request (ignored when empty)
//   head        registered copy of the oldest entry, valid when !empty
//   empty, full status
//   count       entries held
//   drop        push refused because the FIFO is full and nothing is popped
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_next = rd_ptr + 1'b1;

  // NOTE: storage is deliberately left out of reset; count/pointers define validity,
  // and a resettable array would turn the RAM into a bank of flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;

      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // head always holds the entry at rd_ptr for the next cycle; a byte pushed into
      // an empty (or emptying) FIFO bypasses the array.
      if (do_pop) begin
        if (count == (AW+1)'(1)) head <= do_push ? din : '0;
        else                     head <= mem[rd_next];
      end else if (empty && do_push) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampled 8N1 UART receiver with start-glitch rejection, framing-error
// detection and a FWFT receive FIFO.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   rx          serial line (idle high, asynchronous)
//   rx_data     FIFO head byte, valid while rx_valid
//   rx_valid    FIFO non-empty
//   rx_ready    consumer pops the head when rx_valid & rx_ready
//   frame_err   1-cycle pulse, stop bit sampled low
//   overrun     1-cycle pulse, good byte dropped because the FIFO was full
//   fifo_count  entries held
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int CLOCK_FREQ = 62500000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = calc_div(CLOCK_FREQ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             rx_meta;
  logic             rxs;
  logic             rxs_prev;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  rx_state_e        state;
  logic [3:0]       tc;
  logic [2:0]       bi;
  logic [7:0]       shift;
  logic             start_edge;
  logic             stop_sample;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_drop;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop sees the
  // pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign start_edge  = (state == ST_IDLE) && rxs_prev && !rxs;
  assign tick        = (div_cnt == DIV_W'(DIV - 1));
  assign stop_sample = (state == ST_STOP) && tick && (tc == 4'(OVERSAMPLE - 1));
  assign push        = stop_sample && rxs;
  assign pop         = rx_ready && rx_valid;

  // Oversample divider; restarted on the start edge so ticks are phase-aligned to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 div_cnt <= '0;
    else if (start_edge || tick) div_cnt <= '0;
    else                     div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ARM;
      tc        <= '0;
      bi        <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rxs;
      overrun   <= fifo_drop;

      unique case (state)
        // Require a full bit time of idle line before trusting any falling edge.
        ST_ARM: if (tick) begin
          if (!rxs)                             tc <= '0;
          else if (tc == 4'(OVERSAMPLE - 1)) begin
            tc    <= '0;
            state <= ST_IDLE;
          end else                              tc <= tc + 1'b1;
        end

        ST_IDLE: if (start_edge) begin
          tc    <= '0;
          state <= ST_START;
        end

        ST_START: if (tick) begin
          if (tc == 4'(MID_SAMPLE)) begin
            tc <= '0;
            bi <= '0;
            // Line back high at mid start bit: a glitch, silently dropped.
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            tc <= tc + 1'b1;
          end
        end

        ST_DATA: if (tick) begin
          if (tc == 4'(OVERSAMPLE - 1)) begin
            tc    <= '0;
            shift <= {rxs, shift[7:1]};
            if (bi == 3'(DATA_BITS - 1)) state <= ST_STOP;
            else                         bi    <= bi + 1'b1;
          end else begin
            tc <= tc + 1'b1;
          end
        end

        ST_STOP: if (tick) begin
          if (tc == 4'(OVERSAMPLE - 1)) begin
            tc    <= '0;
            // A low stop bit may be a break or misalignment: re-arm on idle line.
            state <= rxs ? ST_IDLE : ST_ARM;
          end else begin
            tc <= tc + 1'b1;
          end
        end

        default: state <= ST_ARM;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift),
    .pop   (pop),
    .head  (rx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at 7.3728 MHz / 115200 baud (4 clk/tick, 64 clk/bit).
module tb_uart_rx_frontend;

  localparam int BIT     = 64;
  localparam int LAT_MAX = 611;  // 9.5 bit times + 3 clocks, counted from the start edge

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic [4:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_frontend #(
    .CLOCK_FREQ (7372800),
    .BAUD       (115200),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  // Check the head and pop it with a one-cycle rx_ready pulse.
  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    int fe_base;
    int ov_base;

    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    // 1. Basic byte and latency from the start edge.
    idle_bits(20);
    cyc = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        while (rx_valid !== 1'b1 && cyc < 700) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    check("t1_latency_ok", (cyc >= 576 && cyc <= LAT_MAX), 1);
    check("t1_count", fifo_count, 1);
    pop_check("t1", 8'h55);
    check("t1_empty_valid", rx_valid, 0);
    check("t1_empty_count", fifo_count, 0);

    // 2. Short low glitch must be ignored.
    idle_bits(2);
    fe_base = fe_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(3);
    check("t2_glitch_valid", rx_valid, 0);
    check("t2_glitch_fe", fe_cnt - fe_base, 0);
    send_byte(8'hA3, 1'b1);
    check("t2_count", fifo_count, 1);
    pop_check("t2", 8'hA3);
    check("t2_empty", rx_valid, 0);

    // 3. Framing error, long low line, recovery.
    idle_bits(2);
    fe_base = fe_cnt;
    send_byte(8'h0F, 1'b0);
    repeat (20 * BIT) @(negedge clk);
    check("t3_fe_pulse", fe_cnt - fe_base, 1);
    check("t3_no_entry", fifo_count, 0);
    idle_bits(3);
    send_byte(8'h81, 1'b1);
    check("t3_fe_total", fe_cnt - fe_base, 1);
    check("t3_count", fifo_count, 1);
    pop_check("t3", 8'h81);

    // 4. Fill past capacity with no consumer.
    idle_bits(2);
    ov_base = ov_cnt;
    fe_base = fe_cnt;
    for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1);
    check("t4_count_full", fifo_count, 16);
    check("t4_overrun", ov_cnt - ov_base, 1);
    check("t4_no_fe", fe_cnt - fe_base, 0);
    for (int i = 0; i < 16; i++) pop_check($sformatf("t4_drain%0d", i), 8'(i));
    check("t4_empty", rx_valid, 0);

    // 5. Full FIFO, pop on the exact push cycle of 0x42.
    idle_bits(2);
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 1'b1);
    check("t5_count_full", fifo_count, 16);
    ov_base = ov_cnt;
    fork
      send_byte(8'h42, 1'b1);
      begin
        repeat (LAT_MAX - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    check("t5_no_overrun", ov_cnt - ov_base, 0);
    check("t5_count", fifo_count, 16);
    for (int i = 1; i < 16; i++) pop_check($sformatf("t5_drain%0d", i), 8'h80 + 8'(i));
    pop_check("t5_last", 8'h42);
    check("t5_empty", rx_valid, 0);

    // 6. Reset in the middle of a frame with a byte already buffered.
    idle_bits(2);
    send_byte(8'h77, 1'b1);
    check("t6_pre_count", fifo_count, 1);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 8'hC3 >> i;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b0;  // bit 4 of 0xC3
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_data", rx_data, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_fe", frame_err, 0);
    check("t6_rst_ov", overrun, 0);
    rst = 1'b0;
    fe_base = fe_cnt;
    repeat (BIT / 2 - 3) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx = 8'hC3 >> i;
      repeat (BIT) @(negedge clk);
    end
    idle_bits(4);
    check("t6_no_spurious", rx_valid, 0);
    check("t6_no_fe", fe_cnt - fe_base, 0);
    send_byte(8'h3C, 1'b1);
    check("t6_count", fifo_count, 1);
    pop_check("t6", 8'h3C);
    check("t6_empty", rx_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
